seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised multi-cycle successor to the team's 32-bit combinational ALU.
- Adds shifts and an iterative unsigned multiply.
- Full NZCV flags and valid/ready handshakes on both input and output.
- Sits between the register-read stage and writeback of the multi-cycle datapath; a stalled consumer back-pressures the ALU.

Parameters:
WIDTH, 32, operand/result width in bits (power of two, >= 8)
SHW, $clog2(WIDTH), shift-amount width (derived, not overridable)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request valid
in_ready  out  1  block can accept a request this cycle
X  in  WIDTH  operand A
Y  in  WIDTH  operand B; for shifts, Y[SHW-1:0] is the shift amount
Aluc  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SRL, 110 SRA, 111 MUL
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
R  out  WIDTH  result
Z  out  1  R == 0
N  out  1  R[WIDTH-1]
C  out  1  carry flag
V  out  1  overflow flag

Behaviour:
- One clock. Reset is asynchronous and active-low: rst_n low forces the FSM to IDLE and R, Z, N, C, V and out_valid to 0, at any time, including mid-operation. The in-flight operation is discarded; no result is produced for it.
- Accept: a request is accepted on a cycle where in_valid && in_ready. X, Y and Aluc are captured at acceptance; later changes on those inputs are ignored.
- in_ready is high in IDLE, and in DONE when out_ready is high (back-to-back issue). It is low in SHIFT and MUL.
- FSM states: IDLE, SHIFT, MUL, DONE.
  - IDLE --accept ADD/SUB/AND/OR--> DONE; result registered at acceptance.
  - IDLE --accept shift, amount n--> SHIFT with counter = n. If n = 0, go directly to DONE with R = X.
  - SHIFT: shift one bit per cycle, decrement counter; go to DONE when counter reaches 1 (final shift that cycle).
  - IDLE --accept MUL--> MUL: shift-add, one multiplier bit per cycle, WIDTH iterations, 2*WIDTH-bit accumulator; then DONE.
  - DONE: out_valid = 1. R and flags are held stable while out_ready is low. On out_ready: go to IDLE, or, if a new request is accepted in the same cycle, take the transition IDLE would take for it.
- Latency, from accept cycle t:
  - ADD/SUB/AND/OR: out_valid at t+1.
  - Shift by n: out_valid at t+1+max(n-1,0). A shift of n >= 1 completes n cycles after t.
  - MUL: out_valid at t+WIDTH+1.
- Arithmetic and flag rules:
  - ADD: R = X+Y mod 2^WIDTH. C = carry out of the MSB. V = signed overflow, i.e. operands have the same sign and the result sign differs.
  - SUB: computed as X + ~Y + 1. C = carry out of that sum (1 = no borrow). V = signed overflow, i.e. operands have different signs and the result sign differs from X.
  - AND/OR: C = 0, V = 0.
  - SLL/SRL: zero fill. SRA: fills with X[WIDTH-1]. C = last bit shifted out (0 when n = 0). V = 0.
  - MUL: unsigned. R = low WIDTH bits of the product. V = 1 if the high WIDTH bits are nonzero. C = 0.
  - Z and N are always derived from the final R.
- Flags change only on the cycle R changes.

Decomposition:
- Package seq_alu_pkg holds the Aluc opcode localparams (OP_ADD … OP_MUL) and the FSM state encoding (2-bit: IDLE, SHIFT, MUL, DONE).
- Sub-module seq_alu_addsub: combinational WIDTH-bit carry-lookahead add/sub built from 4-bit lookahead groups. Outputs sum, carry out and overflow. It is instantiated once; the MUL accumulator step reuses it with its sub input tied to 0.
- Shift datapath and FSM stay in the top module.

Test Plan (WIDTH=32):
- ADD X=0xFFFFFFFF, Y=1 -> out_valid at t+1, R=0, Z=1, C=1, V=0, N=0. SUB X=0x80000000, Y=1 -> R=0x7FFFFFFF, V=1, C=1, N=0.
- AND 0xF0F0F0F0 & 0x0FF00FF0 -> 0x00F000F0. OR of the same operands -> 0xFFF0FFF0. C=V=0 for both.
- SRA X=0x80000001, Y=4 -> R=0xF8000000, C=0, out_valid at t+4. SLL X=0x1234, Y=0 -> R=0x1234 at t+1, C=0. SRL X=0x3, Y=1 -> R=0x1, C=1.
- MUL 7*6 -> R=42, V=0, out_valid at t+33. MUL 0x00010000*0x00010000 -> R=0, Z=1, V=1. in_ready stays low throughout MUL.
- Backpressure: hold out_ready low for 3 cycles after an ADD result -> R and flags stable, in_ready low. Raise out_ready together with in_valid carrying a new SUB -> SUB is accepted that cycle, and its result appears the next cycle.
- Drop rst_n for one cycle mid-MUL (cycle 10) -> out_valid=0, R=0 immediately. After release, in_ready=1 and no stale result is ever presented.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
//   Shared definitions for the sequential ALU:
//     - Aluc opcode encodings (OP_ADD .. OP_MUL)
//     - FSM state encoding (2-bit: IDLE, SHIFT, MUL, DONE)
//     - is_shift() helper used when deciding whether an opcode takes the
//       iterative shift path
// -----------------------------------------------------------------------------
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// -----------------------------------------------------------------------------
// seq_alu_if
//   Request/response bundle of the sequential ALU.
//   Request side : in_valid, in_ready, X, Y, Aluc
//   Response side: out_valid, out_ready, R, Z, N, C, V
//   modport master : the issuing stage (drives requests, consumes results)
//   modport slave  : the ALU itself
// -----------------------------------------------------------------------------
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [2:0]       Aluc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] R;
    logic             Z;
    logic             N;
    logic             C;
    logic             V;

    modport master (
        output in_valid, X, Y, Aluc, out_ready,
        input  in_ready, out_valid, R, Z, N, C, V
    );

    modport slave (
        input  in_valid, X, Y, Aluc, out_ready,
        output in_ready, out_valid, R, Z, N, C, V
    );

endinterface

// File: rtl/seq_alu_addsub.sv
// -----------------------------------------------------------------------------
// seq_alu_addsub
//   Combinational WIDTH-bit adder/subtractor. Carries are resolved with full
//   lookahead inside each 4-bit group; group carries ripple between groups.
//   Subtraction is a + ~b + 1 (carry-in = sub).
//   Ports:
//     a, b  in  WIDTH  operands
//     sub   in  1      1 = subtract
//     sum   out WIDTH  result
//     cout  out 1      carry out of the MSB (for SUB: 1 = no borrow)
//     ovf   out 1      two's-complement overflow
// -----------------------------------------------------------------------------
module seq_alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NGRP = WIDTH / 4;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [NGRP:0]    grp_carry;

    assign b_eff        = b ^ {WIDTH{sub}};
    assign gen          = a & b_eff;
    assign prop         = a ^ b_eff;
    assign grp_carry[0] = sub;

    genvar gi;
    generate
        for (gi = 0; gi < NGRP; gi++) begin : g_grp
            logic [3:0] g4;
            logic [3:0] p4;
            logic [4:0] c4;

            assign g4    = gen[4*gi +: 4];
            assign p4    = prop[4*gi +: 4];
            assign c4[0] = grp_carry[gi];
            assign c4[1] = g4[0] | (p4[0] & c4[0]);
            assign c4[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & c4[0]);
            assign c4[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                         | (p4[2] & p4[1] & p4[0] & c4[0]);
            assign c4[4] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                         | (p4[3] & p4[2] & p4[1] & g4[0])
                         | (p4[3] & p4[2] & p4[1] & p4[0] & c4[0]);

            assign sum[4*gi +: 4] = p4 ^ c4[3:0];
            assign grp_carry[gi+1] = c4[4];
        end
    endgenerate

    assign cout = grp_carry[NGRP];
    // Overflow: effective operands share a sign and the sum's sign differs.
    assign ovf  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
//   Multi-cycle ALU with valid/ready handshakes on request and result.
//   ADD/SUB/AND/OR finish in one cycle, shifts move one bit per cycle, MUL is
//   an unsigned shift-add over WIDTH cycles. Result and NZCV flags are held
//   while the consumer stalls.
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     bus    seq_alu_if.slave: in_valid/in_ready/X/Y/Aluc request,
//            out_valid/out_ready/R/Z/N/C/V result
// -----------------------------------------------------------------------------
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_alu_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;   // counter must hold WIDTH for MUL

    state_t             state_reg;
    logic [2:0]         op_reg;
    logic [WIDTH-1:0]   work_reg;   // partial shift value, or MUL multiplicand
    logic [2*WIDTH-1:0] acc_reg;    // MUL {partial product, remaining multiplier}
    logic [CW-1:0]      cnt_reg;
    logic [WIDTH-1:0]   r_reg;
    logic               z_reg;
    logic               n_reg;
    logic               c_reg;
    logic               v_reg;
    logic               out_valid_reg;

    logic               in_ready;
    logic               accept;
    logic               in_mul;
    logic [SHW-1:0]     shift_amt;

    // ---------------------------------------------------------------- adder
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_sub;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic               add_ovf;

    // Outside MUL the adder serves the incoming request; during MUL it adds
    // the multiplicand into the upper accumulator half.
    assign in_mul  = (state_reg == MUL);
    assign add_a   = in_mul ? acc_reg[2*WIDTH-1:WIDTH] : bus.X;
    assign add_b   = in_mul ? work_reg : bus.Y;
    assign add_sub = !in_mul && (bus.Aluc == OP_SUB);

    seq_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    // ------------------------------------------------------------ MUL step
    // Conditionally add the multiplicand to the high half, then shift the
    // whole accumulator right; the adder's carry becomes the new top bit.
    logic [WIDTH:0]     mul_hi;
    logic [2*WIDTH-1:0] acc_step;

    assign mul_hi   = acc_reg[0] ? {add_cout, add_sum} : {1'b0, acc_reg[2*WIDTH-1:WIDTH]};
    assign acc_step = {mul_hi, acc_reg[WIDTH-1:1]};

    // ---------------------------------------------------------- shift step
    // One-bit shift of either the incoming operand (first bit is shifted on
    // the accept cycle) or the in-progress value.
    logic [WIDTH-1:0]   shift_src;
    logic [2:0]         shift_op;
    logic [WIDTH-1:0]   shift_val;
    logic               shift_bit;

    always_comb begin
        shift_src = (state_reg == SHIFT) ? work_reg : bus.X;
        shift_op  = (state_reg == SHIFT) ? op_reg   : bus.Aluc;
        shift_val = shift_src;
        shift_bit = 1'b0;
        case (shift_op)
            OP_SLL: begin
                shift_val = {shift_src[WIDTH-2:0], 1'b0};
                shift_bit = shift_src[WIDTH-1];
            end
            OP_SRL: begin
                shift_val = {1'b0, shift_src[WIDTH-1:1]};
                shift_bit = shift_src[0];
            end
            OP_SRA: begin
                shift_val = {shift_src[WIDTH-1], shift_src[WIDTH-1:1]};
                shift_bit = shift_src[0];
            end
            default: ;
        endcase
    end

    // ----------------------------------------------------------- handshake
    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready);
    assign accept    = bus.in_valid && in_ready;
    assign shift_amt = bus.Y[SHW-1:0];

    logic start_mul;
    logic start_long_shift;
    logic res_load;

    assign start_mul        = (bus.Aluc == OP_MUL);
    // Shifts of 0 or 1 bit finish on the accept cycle itself.
    assign start_long_shift = is_shift(bus.Aluc) && (shift_amt > SHW'(1));
    assign res_load = (accept && !start_mul && !start_long_shift)
                   || (((state_reg == SHIFT) || in_mul) && (cnt_reg == CW'(1)));

    // ------------------------------------------------------- result select
    // Value and C/V that would be written if a result is produced this cycle.
    logic [WIDTH-1:0] res_val;
    logic             res_c;
    logic             res_v;

    always_comb begin
        res_val = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        case (state_reg)
            SHIFT: begin
                res_val = shift_val;
                res_c   = shift_bit;
            end
            MUL: begin
                res_val = acc_step[WIDTH-1:0];
                res_v   = |acc_step[2*WIDTH-1:WIDTH];
            end
            default: begin
                case (bus.Aluc)
                    OP_ADD, OP_SUB: begin
                        res_val = add_sum;
                        res_c   = add_cout;
                        res_v   = add_ovf;
                    end
                    OP_AND:  res_val = bus.X & bus.Y;
                    OP_OR:   res_val = bus.X | bus.Y;
                    OP_MUL:  res_val = '0;
                    default: begin
                        if (shift_amt == '0) begin
                            res_val = bus.X;
                        end else begin
                            res_val = shift_val;
                            res_c   = shift_bit;
                        end
                    end
                endcase
            end
        endcase
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            op_reg        <= OP_ADD;
            work_reg      <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            r_reg         <= '0;
            z_reg         <= 1'b0;
            n_reg         <= 1'b0;
            c_reg         <= 1'b0;
            v_reg         <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: ;
                SHIFT: begin
                    work_reg <= shift_val;
                    cnt_reg  <= cnt_reg - CW'(1);
                end
                MUL: begin
                    acc_reg <= acc_step;
                    cnt_reg <= cnt_reg - CW'(1);
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // A new request overrides the DONE->IDLE step taken above.
            if (accept) begin
                op_reg <= bus.Aluc;
                if (start_mul) begin
                    work_reg  <= bus.X;
                    acc_reg   <= {{WIDTH{1'b0}}, bus.Y};
                    cnt_reg   <= CW'(WIDTH);
                    state_reg <= MUL;
                end else if (start_long_shift) begin
                    work_reg  <= shift_val;
                    cnt_reg   <= CW'(shift_amt) - CW'(1);
                    state_reg <= SHIFT;
                end
            end

            if (res_load) begin
                r_reg         <= res_val;
                z_reg         <= (res_val == '0);
                n_reg         <= res_val[WIDTH-1];
                c_reg         <= res_c;
                v_reg         <= res_v;
                out_valid_reg <= 1'b1;
                state_reg     <= DONE;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.R         = r_reg;
    assign bus.Z         = z_reg;
    assign bus.N         = n_reg;
    assign bus.C         = c_reg;
    assign bus.V         = v_reg;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
//   Self-checking bench for seq_alu (WIDTH=32): directed cases, back-pressure,
//   mid-MUL reset and randomized operations against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W   = 32;
    localparam int SHW = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic from the operation rules.
    task automatic model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         output logic [W-1:0] r, output logic c, output logic v,
                         output int lat);
        longint sx, sy, s;
        logic [2*W-1:0] prod;
        int n;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        n   = int'(y[SHW-1:0]);
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        lat = 1;
        case (op)
            OP_ADD: begin
                r = x + y;
                c = ({32'd0, x} + {32'd0, y}) > 64'hFFFF_FFFF;
                s = sx + sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                r = x - y;
                c = (x >= y);
                s = sx - sy;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_AND: r = x & y;
            OP_OR:  r = x | y;
            OP_SLL: begin
                r   = x << n;
                c   = (n == 0) ? 1'b0 : x[W-n];
                lat = (n == 0) ? 1 : n;
            end
            OP_SRL: begin
                r   = x >> n;
                c   = (n == 0) ? 1'b0 : x[n-1];
                lat = (n == 0) ? 1 : n;
            end
            OP_SRA: begin
                r   = $signed(x) >>> n;
                c   = (n == 0) ? 1'b0 : x[n-1];
                lat = (n == 0) ? 1 : n;
            end
            default: begin
                prod = {32'd0, x} * {32'd0, y};
                r    = prod[W-1:0];
                v    = (prod[2*W-1:W] != '0);
                lat  = W + 1;
            end
        endcase
    endtask

    // Issue one operation with out_ready high and check the response.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] er;
        logic         ec, ev;
        int           elat, lat;
        logic [W-1:0] prev_r;
        logic         busy_bad;
        model(op, x, y, er, ec, ev, elat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.Aluc      = op;
        bus.X         = x;
        bus.Y         = y;
        bus.out_ready = 1'b1;
        prev_r        = bus.R;
        @(negedge clk);
        // Scramble inputs: the captured operands must be used.
        bus.in_valid = 1'b0;
        bus.X        = $urandom;
        bus.Y        = $urandom;
        bus.Aluc     = 3'($urandom_range(0, 7));
        lat      = 1;
        busy_bad = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready || bus.R !== prev_r) busy_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        $display("op=%0d X=%08h Y=%08h -> R=%08h ZNCV=%b%b%b%b lat=%0d [%s]",
                 op, x, y, bus.R, bus.Z, bus.N, bus.C, bus.V, lat, tag);
        chk({tag, ".lat"},  64'(lat), 64'(elat));
        chk({tag, ".R"},    64'(bus.R), 64'(er));
        chk({tag, ".ZNCV"}, 64'({bus.Z, bus.N, bus.C, bus.V}),
            64'({er == '0, er[W-1], ec, ev}));
        chk({tag, ".busy"}, 64'(busy_bad), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] er, er2;
        logic         ec, ev, ec2, ev2;
        int           elat;
        logic         saw_valid;

        bus.in_valid  = 1'b0;
        bus.X         = '0;
        bus.Y         = '0;
        bus.Aluc      = OP_ADD;
        bus.out_ready = 1'b1;

        // ---------------- reset state
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.valid", 64'(bus.out_valid), 64'(0));
        chk("rst.R",     64'(bus.R), 64'(0));
        chk("rst.ZNCV",  64'({bus.Z, bus.N, bus.C, bus.V}), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("rst.rdy",   64'(bus.in_ready), 64'(1));

        // ---------------- directed cases
        run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1);
        run_op("sub_ovf",  OP_SUB, 32'h8000_0000, 32'h1);
        run_op("and",      OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        run_op("or",       OP_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0);
        run_op("sra4",     OP_SRA, 32'h8000_0001, 32'd4);
        run_op("sll0",     OP_SLL, 32'h0000_1234, 32'd0);
        run_op("srl1",     OP_SRL, 32'h0000_0003, 32'd1);
        run_op("sll31",    OP_SLL, 32'h0000_0003, 32'd31);
        run_op("mul7x6",   OP_MUL, 32'd7, 32'd6);
        run_op("mul_hi",   OP_MUL, 32'h0001_0000, 32'h0001_0000);
        run_op("add_sovf", OP_ADD, 32'h7FFF_FFFF, 32'h1);

        // ---------------- back-pressure and same-cycle reissue
        model(OP_ADD, 32'h1234_5678, 32'h1111_1111, er, ec, ev, elat);
        model(OP_SUB, 32'h0000_0005, 32'h0000_0009, er2, ec2, ev2, elat);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.Aluc      = OP_ADD;
        bus.X         = 32'h1234_5678;
        bus.Y         = 32'h1111_1111;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("bp.valid", 64'(bus.out_valid), 64'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp.hold_R",    64'(bus.R), 64'(er));
            chk("bp.hold_ZNCV", 64'({bus.Z, bus.N, bus.C, bus.V}),
                64'({er == '0, er[W-1], ec, ev}));
            chk("bp.hold_rdy",  64'(bus.in_ready), 64'(0));
            chk("bp.hold_vld",  64'(bus.out_valid), 64'(1));
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.Aluc      = OP_SUB;
        bus.X         = 32'h0000_0005;
        bus.Y         = 32'h0000_0009;
        #1;
        chk("bp.reissue_rdy", 64'(bus.in_ready), 64'(1));
        @(negedge clk);
        bus.in_valid = 1'b0;
        $display("op=%0d X=%08h Y=%08h -> R=%08h ZNCV=%b%b%b%b lat=1 [bp_sub]",
                 OP_SUB, 32'h5, 32'h9, bus.R, bus.Z, bus.N, bus.C, bus.V);
        chk("bp.sub_vld",  64'(bus.out_valid), 64'(1));
        chk("bp.sub_R",    64'(bus.R), 64'(er2));
        chk("bp.sub_ZNCV", 64'({bus.Z, bus.N, bus.C, bus.V}),
            64'({er2 == '0, er2[W-1], ec2, ev2}));

        // ---------------- reset in the middle of a MUL
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.Aluc     = OP_MUL;
        bus.X        = 32'd123;
        bus.Y        = 32'd456;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) begin
            @(negedge clk);
            chk("mulrst.busy_rdy", 64'(bus.in_ready), 64'(0));
        end
        rst_n = 1'b0;
        #1;
        chk("mulrst.valid", 64'(bus.out_valid), 64'(0));
        chk("mulrst.R",     64'(bus.R), 64'(0));
        chk("mulrst.ZNCV",  64'({bus.Z, bus.N, bus.C, bus.V}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mulrst.rdy", 64'(bus.in_ready), 64'(1));
        saw_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) saw_valid = 1'b1;
        end
        $display("mid-MUL reset: stale result seen=%0b", saw_valid);
        chk("mulrst.stale", 64'(saw_valid), 64'(0));

        // ---------------- randomized operations
        for (int i = 0; i < 150; i++) begin
            logic [2:0]   op;
            logic [W-1:0] x, y;
            op = 3'($urandom_range(0, 7));
            x  = $urandom;
            y  = $urandom;
            if ($urandom_range(0, 3) == 0) x = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(0, 15));
            run_op("rand", op, x, y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
